// File: rtl/cell_row_plotter.sv
// Expands 40-cell board rows into CELLxCELL pixel blocks, one registered pixel per cycle.
// A 2-entry row FIFO decouples the row producer from the drawing engine.
module cell_row_plotter #(
  parameter int         COLS         = 40,
  parameter int         ROWS         = 31,
  parameter int         CELL         = 4,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] ALIVE_COLOUR = 3'b111,
  parameter logic [2:0] DEAD_COLOUR  = 3'b000,
  parameter bit         DRAW_DEAD    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            row_valid,
  output logic            row_ready,
  input  logic [4:0]      row_idx,
  input  logic [COLS-1:0] row_data,
  output logic [7:0]      x,
  output logic [6:0]      y,
  output logic [2:0]      colour,
  output logic            plot,
  output logic            busy,
  output logic            frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(CELL);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t          state, state_next;
  logic [4:0]      fifo_idx  [2];
  logic [COLS-1:0] fifo_data [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count, count_next;
  logic            push, pop;

  logic [COLS-1:0] row_reg;
  logic [4:0]      idx_reg;
  logic [CW-1:0]   col, col_bit;
  logic [SW-1:0]   sx, sy;
  logic            cell_alive, skip, step_done, last_col;
  logic [7:0]      x_next;
  int              y_full;

  assign push       = row_valid && row_ready;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign busy       = (count != 2'd0) || (state != IDLE);

  // NOTE: FIFO storage is not reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= row_idx;
      fifo_data[wr_ptr] <= row_data;
    end
  end

  // row_ready comes from the next count, so it is registered and never sees pop combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      row_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count     <= count_next;
      row_ready <= (count_next != 2'd2);
    end
  end

  assign col_bit    = CW'(COLS - 1) - col;
  assign cell_alive = row_reg[col_bit];
  assign skip       = !DRAW_DEAD && !cell_alive;
  assign step_done  = skip || ((&sx) && (&sy));
  assign last_col   = (col == CW'(COLS - 1));
  assign x_next     = 8'(int'(col) * CELL + int'(sx));
  assign y_full     = int'(idx_reg) * CELL + int'(sy);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (count != 2'd0) state_next = LOAD;
      LOAD: begin
        pop        = 1'b1;
        state_next = (int'(fifo_idx[rd_ptr]) < ROWS) ? DRAW : IDLE;
      end
      DRAW: if (step_done && last_col) state_next = DONE;
      DONE: state_next = (count != 2'd0) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pixel outputs are registered from the DRAW step, so they trail the engine by one cycle;
  // frame_done likewise lands in the cycle after DONE, right after the row's last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg    <= '0;
      idx_reg    <= '0;
      col        <= '0;
      sx         <= '0;
      sy         <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          row_reg <= fifo_data[rd_ptr];
          idx_reg <= fifo_idx[rd_ptr];
          col     <= '0;
          sx      <= '0;
          sy      <= '0;
        end
        DRAW: begin
          x      <= x_next;
          y      <= 7'(y_full);
          colour <= cell_alive ? ALIVE_COLOUR : DEAD_COLOUR;
          plot   <= !skip && (y_full < SCREEN_H);
          if (step_done) begin
            sx  <= '0;
            sy  <= '0;
            col <= col + 1'b1;
          end else begin
            sx <= sx + 1'b1;
            if (&sx) sy <= sy + 1'b1;
          end
        end
        DONE: frame_done <= (int'(idx_reg) == ROWS - 1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_row_plotter.sv
// Self-checking bench for cell_row_plotter: two instances (dead cells drawn / skipped),
// compared cycle by cycle against a per-row pixel-trace model built from the drawing rules.
module tb_cell_row_plotter;

  localparam int COLS = 40, ROWS = 31, CELL = 4, SCREEN_H = 120;

  typedef struct {
    bit         step;
    bit         plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    bit         fd;
  } samp_t;

  logic            clk = 1'b0, reset = 1'b1, row_valid = 1'b0, sel = 1'b0;
  logic [4:0]      row_idx = '0;
  logic [COLS-1:0] row_data = '0;

  logic       ready_a, plot_a, busy_a, fd_a, ready_b, plot_b, busy_b, fd_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] col_a, col_b;
  logic       ready_m, plot_m, busy_m, fd_m;
  logic [7:0] x_m;
  logic [6:0] y_m;
  logic [2:0] col_m;

  int vectors = 0, miscompares = 0, fd_count = 0, cyc = 0;
  samp_t           exp_q[$];
  logic [4:0]      pend_idx[$];
  logic [COLS-1:0] pend_data[$];
  int              acc_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cell_row_plotter #(.DRAW_DEAD(1'b1)) dut_a (
    .clk(clk), .reset(reset), .row_valid(row_valid && !sel), .row_ready(ready_a),
    .row_idx(row_idx), .row_data(row_data), .x(x_a), .y(y_a), .colour(col_a),
    .plot(plot_a), .busy(busy_a), .frame_done(fd_a));

  cell_row_plotter #(.DRAW_DEAD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .row_valid(row_valid && sel), .row_ready(ready_b),
    .row_idx(row_idx), .row_data(row_data), .x(x_b), .y(y_b), .colour(col_b),
    .plot(plot_b), .busy(busy_b), .frame_done(fd_b));

  assign ready_m = sel ? ready_b : ready_a;
  assign plot_m  = sel ? plot_b  : plot_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign fd_m    = sel ? fd_b    : fd_a;
  assign x_m     = sel ? x_b     : x_a;
  assign y_m     = sel ? y_b     : y_a;
  assign col_m   = sel ? col_b   : col_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic add_gap(input bit fd);
    samp_t s;
    s.step = 1'b0; s.plot = 1'b0; s.x = '0; s.y = '0; s.colour = '0; s.fd = fd;
    exp_q.push_back(s);
  endtask

  // Reference: every cell is a CELLxCELL block scanned row-major, or one blank
  // cycle when dead cells are not drawn; two quiet cycles follow each row.
  task automatic model_row(input int idx, input logic [COLS-1:0] data, input bit draw_dead);
    samp_t s;
    for (int c = 0; c < COLS; c++) begin
      bit alive;
      alive = data[COLS-1-c];
      if (!alive && !draw_dead) begin
        s.step = 1'b1; s.plot = 1'b0; s.x = '0; s.y = '0; s.colour = '0; s.fd = 1'b0;
        exp_q.push_back(s);
      end else begin
        for (int py = 0; py < CELL; py++)
          for (int px = 0; px < CELL; px++) begin
            s.step   = 1'b1;
            s.plot   = (idx * CELL + py) < SCREEN_H;
            s.x      = 8'(c * CELL + px);
            s.y      = 7'(idx * CELL + py);
            s.colour = alive ? 3'b111 : 3'b000;
            s.fd     = 1'b0;
            exp_q.push_back(s);
          end
      end
    end
    add_gap(idx == ROWS - 1);
    add_gap(1'b0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_row(input logic [4:0] idx, input logic [COLS-1:0] data);
    int waited;
    waited = 0;
    row_idx = idx; row_data = data; row_valid = 1'b1;
    while (!ready_m && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("row_ready_wait", ready_m, 1);
    @(negedge clk);
    acc_cyc.push_back(cyc);
  endtask

  task automatic check_trace(input int limit);
    samp_t e;
    int n;
    n = 0;
    while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n++;
      if (fd_m) fd_count++;
      chk("plot", plot_m, e.plot);
      if (e.plot) begin
        chk("x", x_m, e.x);
        chk("y", y_m, e.y);
        chk("colour", col_m, e.colour);
      end
      chk("frame_done", fd_m, e.fd);
      if (e.step) chk("busy", busy_m, 1);
    end
  endtask

  // Pushes all pending rows with row_valid held high while checking the output trace.
  task automatic run(input int limit);
    exp_q.delete();
    acc_cyc.delete();
    fd_count = 0;
    add_gap(1'b0);
    add_gap(1'b0);
    foreach (pend_idx[i]) model_row(int'(pend_idx[i]), pend_data[i], !sel);
    push_row(pend_idx[0], pend_data[0]);
    fork
      begin
        for (int i = 1; i < pend_idx.size(); i++) push_row(pend_idx[i], pend_data[i]);
        row_valid = 1'b0;
      end
      check_trace(limit);
    join
  endtask

  function automatic logic [COLS-1:0] rand_row();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[COLS-1:0];
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_plot"}, plot_m, 0);
    chk({tag, "_x"}, x_m, 0);
    chk({tag, "_y"}, y_m, 0);
    chk({tag, "_colour"}, col_m, 0);
    chk({tag, "_busy"}, busy_m, 0);
    chk({tag, "_frame_done"}, fd_m, 0);
    chk({tag, "_row_ready"}, ready_m, 0);
  endtask

  initial begin
    logic [COLS-1:0] d;

    // Reset state and row_ready rising one cycle after reset falls
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready_m, 1);
    chk("busy_idle", busy_m, 0);

    // T1: leftmost cell alive, dead cells drawn
    pend_idx = '{5'd0};
    d = '0; d[COLS-1] = 1'b1;
    pend_data = '{d};
    run(-1);
    chk("t1_busy_end", busy_m, 0);

    // T3: bottom row fully clipped, frame_done once
    pend_idx = '{5'd30};
    pend_data = '{{COLS{1'b1}}};
    run(-1);
    chk("t3_fd_count", fd_count, 1);

    // T4: three random rows back to back
    pend_idx = '{5'($urandom_range(0, 29)), 5'($urandom_range(0, 29)), 5'($urandom_range(0, 29))};
    pend_data = '{rand_row(), rand_row(), rand_row()};
    run(-1);
    chk("t4_second_accept", acc_cyc[1] - acc_cyc[0], 1);
    chk("t4_third_accept", acc_cyc[2] - acc_cyc[0], 3);

    // T2: dead cells skipped, cols 2..3 alive
    sel = 1'b1;
    @(negedge clk);
    pend_idx = '{5'd5};
    d = '0; d[37] = 1'b1; d[36] = 1'b1;
    pend_data = '{d};
    run(-1);
    chk("t2_busy_end", busy_m, 0);

    // Random rows on the skipping instance, including the bottom row
    pend_idx = '{5'($urandom_range(0, 30)), 5'd30, 5'($urandom_range(0, 30)), 5'($urandom_range(0, 30))};
    pend_data = '{rand_row(), rand_row(), rand_row(), rand_row()};
    run(-1);
    chk("rand_fd_count", fd_count, 1);

    // T5: out-of-range row is discarded silently
    sel = 1'b0;
    @(negedge clk);
    push_row(5'd31, rand_row());
    row_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_discard_plot", plot_m, 0);
      chk("t5_discard_fd", fd_m, 0);
    end
    chk("t5_discard_busy", busy_m, 0);

    // T5: reset at the 100th pixel of row 3
    pend_idx = '{5'd3};
    pend_data = '{{COLS{1'b1}}};
    run(102);
    chk("t5_pixel100_plot", plot_m, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("t5_reset");
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ready_after_reset", ready_m, 1);
    chk("t5_plot_after_reset", plot_m, 0);
    chk("t5_busy_after_reset", busy_m, 0);

    // T6: full frame, rows 0..30
    pend_idx.delete();
    pend_data.delete();
    for (int r = 0; r < ROWS; r++) begin
      pend_idx.push_back(5'(r));
      pend_data.push_back(rand_row());
    end
    run(-1);
    chk("t6_fd_count", fd_count, 1);
    chk("t6_busy_end", busy_m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
